// File: rtl/apb_master_requester.sv
// ---------------------------------------------------------------------------
// apb_master_requester
//   APB4 requester that turns single-word command requests into APB
//   transfers. It sequences IDLE -> SETUP -> ACCESS -> RESP. It generates
//   per-byte address/write-data parity and strobe parity. It checks
//   PRDATACHK on reads and returns a one-cycle response with error status.
//
//   Optional feature macro: APB_MASTER_TIMEOUT_EN
//     When defined, an ACCESS cycle that runs TIMEOUT_CYCLES cycles without
//     PREADY is aborted with rsp_timeout=1. When undefined, ACCESS waits
//     indefinitely and rsp_timeout is tied to 0.
//
// Ports
//   PCLK, PRESET          clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (accepted only in IDLE)
//   cmd_write/addr/wdata/strb   command payload
//   rsp_valid             one-cycle response pulse
//   rsp_rdata             read data (0 for writes)
//   rsp_slverr            slave error reported with the response
//   rsp_parity_err        read-data parity mismatch reported with the response
//   rsp_timeout           timeout abort reported with the response
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB   APB request outputs
//   PADDRCHK/PWDATACHK/PSTRBCHK              APB request parity outputs
//   PREADY/PSLVERR/PRDATA/PRDATACHK          APB completer inputs
// ---------------------------------------------------------------------------
module apb_master_requester #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [STRB_WIDTH-1:0]   cmd_strb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_parity_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [STRB_WIDTH-1:0]   PSTRB,
  output logic [ADDR_WIDTH/8-1:0] PADDRCHK,
  output logic [DATA_WIDTH/8-1:0] PWDATACHK,
  output logic                    PSTRBCHK,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic [DATA_WIDTH/8-1:0] PRDATACHK
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic                      r_write;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [STRB_WIDTH-1:0]     r_strb;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic                      r_slverr;
  logic                      r_perr;

  logic                      w_handshake;
  logic                      w_done;
  logic                      w_timeout_hit;
  logic [DATA_WIDTH/8-1:0]   w_rd_par;
  logic                      w_rd_mismatch;

  // cmd_ready is held low while reset is asserted so that every output reads
  // 0 during reset and the first acceptance can only follow reset release.
  assign cmd_ready   = (r_state == S_IDLE) && !PRESET;
  assign w_handshake = cmd_valid && cmd_ready;
  assign w_done      = (r_state == S_ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  // r_cnt counts completed PREADY=0 ACCESS cycles. The abort fires in the
  // TIMEOUT_CYCLES-th such cycle. A PREADY in that same cycle takes priority
  // through w_done.
  assign w_timeout_hit = (r_state == S_ACCESS) && !PREADY && (r_cnt == TO_LAST);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !PREADY) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_timeout <= 1'b0;
    end else if (w_done) begin
      r_timeout <= 1'b0;
    end else if (w_timeout_hit) begin
      r_timeout <= 1'b1;
    end
  end

  assign rsp_timeout = (r_state == S_RESP) && r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign rsp_timeout   = 1'b0;
`endif

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_handshake) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_done || w_timeout_hit) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Command register. Write data and strobes are zeroed for reads so that
  // PWDATA/PSTRB read as 0 for the whole read transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (w_handshake) begin
      r_write <= cmd_write;
      r_addr  <= cmd_addr;
      r_wdata <= cmd_write ? cmd_wdata : '0;
      r_strb  <= cmd_write ? cmd_strb  : '0;
    end
  end

  // Read-data parity check on the completing cycle
  always_comb begin
    w_rd_par = '0;
    for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
      w_rd_par[i] = ^PRDATA[8*i +: 8];
    end
  end
  assign w_rd_mismatch = |(PRDATACHK ^ w_rd_par);

  // Response capture
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_rdata  <= '0;
      r_slverr <= 1'b0;
      r_perr   <= 1'b0;
    end else if (w_done) begin
      r_rdata  <= r_write ? '0 : PRDATA;
      r_slverr <= PSLVERR;
      r_perr   <= !r_write && w_rd_mismatch;
    end else if (w_timeout_hit) begin
      r_rdata  <= '0;
      r_slverr <= 1'b0;
      r_perr   <= 1'b0;
    end
  end

  assign rsp_valid      = (r_state == S_RESP);
  assign rsp_rdata      = rsp_valid ? r_rdata : '0;
  assign rsp_slverr     = rsp_valid && r_slverr;
  assign rsp_parity_err = rsp_valid && r_perr;

  // APB request outputs
  assign PSEL    = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign PENABLE = (r_state == S_ACCESS);
  assign PWRITE  = r_write;
  assign PADDR   = r_addr;
  assign PWDATA  = r_wdata;
  assign PSTRB   = r_strb;

  always_comb begin
    PADDRCHK  = '0;
    PWDATACHK = '0;
    for (int unsigned i = 0; i < ADDR_WIDTH / 8; i++) begin
      PADDRCHK[i] = ^PADDR[8*i +: 8];
    end
    for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
      PWDATACHK[i] = ^PWDATA[8*i +: 8];
    end
  end
  assign PSTRBCHK = ^PSTRB;

endmodule

// File: tb/tb_apb_master_requester.sv
module tb_apb_master_requester;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TOC = 16;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_slverr, rsp_parity_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PSTRBCHK;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [AW/8-1:0] PADDRCHK;
  logic [DW/8-1:0] PWDATACHK;
  logic          PREADY, PSLVERR;
  logic [DW-1:0] PRDATA;
  logic [DW/8-1:0] PRDATACHK;

  int n_checks = 0;
  int n_err    = 0;

  apb_master_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_parity_err(rsp_parity_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PADDRCHK(PADDRCHK),
    .PWDATACHK(PWDATACHK), .PSTRBCHK(PSTRBCHK),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA), .PRDATACHK(PRDATACHK)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: byte-wise even parity computed from bit counts.
  function automatic logic [3:0] bpar(input logic [31:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = 1'(($countones(v[8*i +: 8])) % 2);
    return r;
  endfunction

  function automatic logic par(input logic [7:0] v);
    return 1'(($countones(v)) % 2);
  endfunction

  // One complete transfer against a slave that inserts 'waits' wait states.
  task automatic do_xfer(input string tag, input bit wr, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [3:0] st, input int waits,
                         input logic [31:0] rd, input logic [3:0] rchk,
                         input bit serr, input bit serr_wait);
    logic [31:0] exp_wd;
    logic [3:0]  exp_st;
    logic [31:0] exp_rd;
    bit          exp_perr;
    exp_wd   = wr ? wd : 32'h0;
    exp_st   = wr ? st : 4'h0;
    exp_rd   = wr ? 32'h0 : rd;
    exp_perr = !wr && (rchk != bpar(rd));

    @(negedge PCLK);
    chk({tag, ".idle_ready"}, cmd_ready, 1);
    chk({tag, ".idle_rsp"}, rsp_valid, 0);
    chk({tag, ".idle_psel"}, PSEL, 0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
    @(posedge PCLK);
    @(negedge PCLK);
    // Keep a different command pending: it must be ignored outside IDLE.
    cmd_addr = ~addr; cmd_wdata = $urandom; cmd_strb = ~st; cmd_write = ~wr;
    chk({tag, ".setup_psel"}, PSEL, 1);
    chk({tag, ".setup_pen"}, PENABLE, 0);
    chk({tag, ".setup_ready"}, cmd_ready, 0);
    chk({tag, ".setup_paddr"}, PADDR, addr);
    chk({tag, ".setup_pwrite"}, PWRITE, wr);
    chk({tag, ".setup_pwdata"}, PWDATA, exp_wd);
    chk({tag, ".setup_pstrb"}, PSTRB, exp_st);
    chk({tag, ".setup_paddrchk"}, PADDRCHK, par(addr));
    chk({tag, ".setup_pwdatachk"}, PWDATACHK, bpar(exp_wd));
    chk({tag, ".setup_pstrbchk"}, PSTRBCHK, par({4'h0, exp_st}));
    @(posedge PCLK);
    for (int k = 0; k <= waits; k++) begin
      @(negedge PCLK);
      chk({tag, ".acc_psel"}, {PSEL, PENABLE}, 2'b11);
      chk({tag, ".acc_stable"}, {PWRITE, PADDR, PWDATA, PSTRB}, {wr, addr, exp_wd, exp_st});
      chk({tag, ".acc_rsp"}, rsp_valid, 0);
      PREADY    = (k == waits);
      PSLVERR   = (k == waits) ? serr : serr_wait;
      PRDATA    = (k == waits) ? rd   : $urandom;
      PRDATACHK = (k == waits) ? rchk : 4'($urandom);
      @(posedge PCLK);
    end
    @(negedge PCLK);
    cmd_valid = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    chk({tag, ".rsp_valid"}, rsp_valid, 1);
    chk({tag, ".rsp_rdata"}, rsp_rdata, exp_rd);
    chk({tag, ".rsp_slverr"}, rsp_slverr, serr);
    chk({tag, ".rsp_perr"}, rsp_parity_err, exp_perr);
    chk({tag, ".rsp_timeout"}, rsp_timeout, 0);
    chk({tag, ".rsp_psel"}, {PSEL, PENABLE}, 2'b00);
    chk({tag, ".rsp_ready"}, cmd_ready, 0);
    @(posedge PCLK);
  endtask

  initial begin
    logic [31:0] rd;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    PRDATA = '0; PRDATACHK = '0;

    // Reset state
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("reset.outs", {cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_parity_err,
                       rsp_timeout, PSEL, PENABLE, PWRITE}, '0);
    chk("reset.apb", {PADDR, PWDATA, PSTRB, PADDRCHK, PWDATACHK, PSTRBCHK}, '0);
    PRESET = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("reset.ready_after", cmd_ready, 1);
    @(posedge PCLK);

    // Directed transfers
    do_xfer("wr_a5", 1, 8'h04, 32'h0000_00A5, 4'b0001, 0, 32'h0, 4'h0, 0, 0);
    do_xfer("rd_ws2", 0, 8'h08, 32'hDEAD_BEEF, 4'hF, 2, 32'h0000_0003, 4'b0000, 0, 0);
    do_xfer("rd_perr", 0, 8'h08, 32'h0, 4'h0, 2, 32'h0000_0003, 4'b0001, 0, 0);
    do_xfer("rd_slverr", 0, 8'h1F, 32'h0, 4'h0, 0, 32'h1234_5678, bpar(32'h1234_5678), 1, 0);
    do_xfer("rd_slverr_wait", 0, 8'h1F, 32'h0, 4'h0, 3, 32'h0, 4'h0, 0, 1);
    do_xfer("wr_slverr", 1, 8'hFF, 32'hFFFF_FFFF, 4'hF, 1, 32'h5555_5555, 4'hF, 1, 0);

    // Randomized transfers
    for (int n = 0; n < 24; n++) begin
      bit          wr;
      logic [3:0]  rchk;
      wr   = 1'($urandom_range(0, 1));
      rd   = $urandom;
      rchk = ($urandom_range(0, 2) == 0) ? 4'($urandom) : bpar(rd);
      do_xfer("rand", wr, 8'($urandom), $urandom, 4'($urandom), $urandom_range(0, 4),
              rd, rchk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Slave holding PREADY low
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0; PSLVERR = 1'b1;
    @(posedge PCLK);
`ifdef APB_MASTER_TIMEOUT_EN
    for (int k = 0; k < TOC; k++) begin
      @(negedge PCLK);
      chk("to.access", {PSEL, PENABLE, rsp_valid}, 3'b110);
      @(posedge PCLK);
    end
    @(negedge PCLK);
    chk("to.psel_drop", {PSEL, PENABLE}, 2'b00);
    chk("to.rsp", {rsp_valid, rsp_timeout, rsp_slverr, rsp_parity_err}, 4'b1100);
    chk("to.rdata", rsp_rdata, 0);
    PSLVERR = 1'b0;
    @(posedge PCLK);
`else
    repeat (100) @(posedge PCLK);
    @(negedge PCLK);
    chk("hang.still_access", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b1100);
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hCAFE_0001; PRDATACHK = bpar(32'hCAFE_0001);
    @(posedge PCLK);
    @(negedge PCLK);
    PREADY = 1'b0;
    chk("hang.rsp", {rsp_valid, rsp_timeout, rsp_slverr, rsp_parity_err}, 4'b1000);
    chk("hang.rdata", rsp_rdata, 32'hCAFE_0001);
    @(posedge PCLK);
`endif

    // Reset during the second ACCESS cycle
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 32'h1; cmd_strb = 4'h1;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_mid.acc1", {PSEL, PENABLE}, 2'b11);
    @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_mid.acc2", {PSEL, PENABLE}, 2'b11);
    PRESET = 1'b1; PREADY = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_mid.drop", {PSEL, PENABLE, rsp_valid}, 3'b000);
    PRESET = 1'b0; PREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      chk("rst_mid.no_rsp", {rsp_valid, PSEL, cmd_ready}, 3'b001);
    end
    @(posedge PCLK);

    // A normal transfer after the aborted one
    do_xfer("post_rst", 0, 8'h0C, 32'h0, 4'h0, 1, 32'h00FF_00FF, bpar(32'h00FF_00FF), 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
